// File: rtl/neuron_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_seq_pkg
//  Description : Shared types and constants for the layer-level neuron
//                sequencer: state encoding, data width, descriptor layout
//                and the descriptor address helper.
//  Options     : NEURON_SEQ_TIMEOUT_EN (drain watchdog, see neuron_seq_ctrl)
//  Revision    : 1.0 - initial release
// ============================================================================
package neuron_seq_pkg;

  // Width of addresses, counts and descriptor words
  localparam int DATA_W      = 16;
  // Descriptor words per neuron
  localparam int DESC_STRIDE = 2;
  // Drain watchdog limit in cycles (only used with the watchdog build)
  localparam int TIMEOUT_CYC = 8;

  // Word offsets inside one neuron descriptor
  localparam logic [DATA_W-1:0] DESC_NUMADDS = DATA_W'(0);
  localparam logic [DATA_W-1:0] DESC_OFFSET  = DATA_W'(1);

  // Sequencer states
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_DESC_A = 4'd1,
    ST_DESC_B = 4'd2,
    ST_DESC_C = 4'd3,
    ST_LOAD   = 4'd4,
    ST_RUN    = 4'd5,
    ST_DRAIN  = 4'd6,
    ST_COMMIT = 4'd7,
    ST_FINISH = 4'd8
  } state_t;

  // Address of one descriptor word; arithmetic wraps modulo 2^DATA_W
  function automatic logic [DATA_W-1:0] desc_word_addr(
    input logic [DATA_W-1:0] base,
    input logic [DATA_W-1:0] idx,
    input logic [DATA_W-1:0] word
  );
    return base + (DATA_W'(DESC_STRIDE) * idx) + word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_op_counter.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_op_counter
//  Description : Per-neuron operation bookkeeping. Holds the remaining
//                startFetch count (load / decrement, zero-guarded) and counts
//                returning WE strobes, flagging when the count including the
//                strobe of the current cycle equals numAdds.
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_op_counter
  import neuron_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,      // restart both counters for a new neuron
  input  logic [DATA_W-1:0] num_adds,  // operand pairs of the current neuron
  input  logic              dec,       // one startFetch issued this cycle
  input  logic              we_en,     // WE strobes are meaningful this cycle
  input  logic              we_in,     // WE strobe from the fetch unit
  output logic              op_last,   // current startFetch is the final one
  output logic              we_done    // all WE strobes seen, this one included
);

  logic [DATA_W-1:0] op_cnt_q, op_cnt_d;
  logic [DATA_W-1:0] we_cnt_q, we_cnt_d;
  logic [DATA_W-1:0] we_cnt_nxt;
  logic              op_zero;
  logic              we_hit;

  assign op_zero    = (op_cnt_q == '0);
  assign op_last    = (op_cnt_q == DATA_W'(1));
  assign we_hit     = we_en & we_in;
  assign we_cnt_nxt = we_cnt_q + DATA_W'(we_hit);
  // Looking at the incremented value lets the sequencer leave DRAIN in the
  // same cycle the final strobe arrives.
  assign we_done    = (we_cnt_nxt == num_adds);

  // Next-count selection: load wins, otherwise decrement and accumulate
  always_comb begin
    op_cnt_d = op_cnt_q;
    we_cnt_d = we_cnt_q;
    if (load) begin
      op_cnt_d = num_adds;
      we_cnt_d = '0;
    end else begin
      if (dec && !op_zero) begin
        op_cnt_d = op_cnt_q - DATA_W'(1);
      end
      we_cnt_d = we_cnt_nxt;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt_q <= '0;
      we_cnt_q <= '0;
    end else begin
      op_cnt_q <= op_cnt_d;
      we_cnt_q <= we_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/neuron_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_seq_ctrl
//  Description : Layer-level sequencer for the parameter-fetch datapath.
//                Per neuron: read the (numAdds, offset) descriptor, reload
//                the fetch unit, stream startFetch for numAdds cycles, wait
//                for the matching WE strobes and commit the accumulator.
//                All outputs are registered and line up with the state.
//  Options     : NEURON_SEQ_TIMEOUT_EN - drain watchdog with sticky err flag;
//                without it err is tied low and DRAIN waits indefinitely.
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_seq_ctrl
  import neuron_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] numNeurons,
  input  logic [DATA_W-1:0] descBase,
  output logic [DATA_W-1:0] descAddr,
  input  logic [DATA_W-1:0] descVal,
  output logic [DATA_W-1:0] pfNumAdds,
  output logic [DATA_W-1:0] pfOffset,
  output logic              pfLoad,
  output logic              pfStart,
  input  logic              pfWE,
  output logic              accClear,
  output logic              resWE,
  output logic [DATA_W-1:0] resAddr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] num_neurons_q, num_neurons_d;
  logic [DATA_W-1:0] desc_base_q, desc_base_d;
  logic [DATA_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] desc_addr_q, desc_addr_d;
  logic [DATA_W-1:0] pf_num_adds_q, pf_num_adds_d;
  logic [DATA_W-1:0] pf_offset_q, pf_offset_d;
  logic [DATA_W-1:0] res_addr_q, res_addr_d;
  logic              pf_load_q, pf_load_d;
  logic              pf_start_q, pf_start_d;
  logic              acc_clear_q, acc_clear_d;
  logic              res_we_q, res_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] idx_inc;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_we_en;
  logic              op_last;
  logic              we_done;
  logic              wd_expire;

  assign idx_inc = idx_q + DATA_W'(1);

  // ---------------------------------------------------------------------------
  // Operation / WE bookkeeping
  // ---------------------------------------------------------------------------
  // Counters are (re)loaded on the edge into LOAD so a strobe arriving while
  // in LOAD is already counted.
  assign cnt_load  = (state_d == ST_LOAD);
  assign cnt_dec   = (state_q == ST_RUN);
  assign cnt_we_en = (state_q == ST_LOAD) || (state_q == ST_RUN) ||
                     (state_q == ST_DRAIN);

  neuron_op_counter u_op_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .num_adds (pf_num_adds_q),
    .dec      (cnt_dec),
    .we_en    (cnt_we_en),
    .we_in    (pfWE),
    .op_last  (op_last),
    .we_done  (we_done)
  );

  // ---------------------------------------------------------------------------
  // Optional drain watchdog
  // ---------------------------------------------------------------------------
`ifdef NEURON_SEQ_TIMEOUT_EN
  logic [DATA_W-1:0] drain_cnt_q, drain_cnt_d;
  logic              err_q, err_d;

  // Fires on the TIMEOUT_CYC-th DRAIN cycle unless the last strobe is in
  assign wd_expire = (state_q == ST_DRAIN) && !we_done &&
                     (drain_cnt_q == DATA_W'(TIMEOUT_CYC - 1));

  // Count DRAIN cycles; err is sticky until reset
  always_comb begin
    drain_cnt_d = (state_q == ST_DRAIN) ? drain_cnt_q + DATA_W'(1) : '0;
    err_d       = err_q | wd_expire;
  end

  // Watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      drain_cnt_q <= drain_cnt_d;
      err_q       <= err_d;
    end
  end

  assign err = err_q;
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and layer bookkeeping
  // ---------------------------------------------------------------------------
  // State transitions; start is only looked at in IDLE
  always_comb begin
    state_d       = state_q;
    num_neurons_d = num_neurons_q;
    desc_base_d   = desc_base_q;
    idx_d         = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_neurons_d = numNeurons;
          desc_base_d   = descBase;
          idx_d         = '0;
          state_d       = (numNeurons == '0) ? ST_FINISH : ST_DESC_A;
        end
      end
      ST_DESC_A: state_d = ST_DESC_B;
      ST_DESC_B: state_d = ST_DESC_C;
      // An empty neuron skips the fetch entirely but still commits
      ST_DESC_C: state_d = (pf_num_adds_q == '0) ? ST_COMMIT : ST_LOAD;
      ST_LOAD:   state_d = ST_RUN;
      ST_RUN: begin
        if (op_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (we_done || wd_expire) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == num_neurons_q) ? ST_FINISH : ST_DESC_A;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, decoded from the state being entered
  // ---------------------------------------------------------------------------
  // Output values for the next cycle so every output lines up with its state
  always_comb begin
    desc_addr_d = desc_addr_q;
    if (state_d == ST_DESC_A) begin
      desc_addr_d = desc_word_addr(desc_base_d, idx_d, DESC_NUMADDS);
    end else if (state_d == ST_DESC_B) begin
      desc_addr_d = desc_word_addr(desc_base_q, idx_q, DESC_OFFSET);
    end

    // RAM data for the word addressed in the previous cycle arrives now
    pf_num_adds_d = (state_q == ST_DESC_B) ? descVal : pf_num_adds_q;
    pf_offset_d   = (state_q == ST_DESC_C) ? descVal : pf_offset_q;

    pf_load_d  = (state_d == ST_LOAD);
    pf_start_d = (state_d == ST_RUN);
    // Empty neurons never pass through LOAD, so they get their accumulator
    // clear in DESC_C instead to commit a zero result.
    acc_clear_d = (state_d == ST_LOAD) ||
                  ((state_q == ST_DESC_B) && (descVal == '0));

    res_we_d   = (state_d == ST_COMMIT);
    res_addr_d = (state_d == ST_COMMIT) ? idx_q : res_addr_q;

    busy_d = (state_d != ST_IDLE) && (state_d != ST_FINISH);
    done_d = (state_d == ST_FINISH);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      num_neurons_q <= '0;
      desc_base_q   <= '0;
      idx_q         <= '0;
      desc_addr_q   <= '0;
      pf_num_adds_q <= '0;
      pf_offset_q   <= '0;
      res_addr_q    <= '0;
      pf_load_q     <= 1'b0;
      pf_start_q    <= 1'b0;
      acc_clear_q   <= 1'b0;
      res_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_neurons_q <= num_neurons_d;
      desc_base_q   <= desc_base_d;
      idx_q         <= idx_d;
      desc_addr_q   <= desc_addr_d;
      pf_num_adds_q <= pf_num_adds_d;
      pf_offset_q   <= pf_offset_d;
      res_addr_q    <= res_addr_d;
      pf_load_q     <= pf_load_d;
      pf_start_q    <= pf_start_d;
      acc_clear_q   <= acc_clear_d;
      res_we_q      <= res_we_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign descAddr  = desc_addr_q;
  assign pfNumAdds = pf_num_adds_q;
  assign pfOffset  = pf_offset_q;
  assign pfLoad    = pf_load_q;
  assign pfStart   = pf_start_q;
  assign accClear  = acc_clear_q;
  assign resWE     = res_we_q;
  assign resAddr   = res_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire
